store_bank_scheduler: RTL
=========================

// Module: store_bank_scheduler
// PURPOSE
//  Parametrised, sequential successor to the combinational store-data block. Sits between the
//  scalar/VLSU store path and the banked data memory. Buffers store requests in a FIFO and issues
//  each lane's word to its memory bank. Same-bank lane conflicts are serialised over extra cycles.
//  Also generates per-bank byte enables and shifted write data for scalar sb/sh/sw.
// PARAMETERS
//  NUM_BANKS   4   memory banks; power of 2, >=2; bank = word_addr[log2(NUM_BANKS)-1:0]
//  NUM_LANES   4   store lanes per request (lane 0 carries scalar stores)
//  ADDR_W      12  word-address width per lane; row = word_addr >> log2(NUM_BANKS)
//  FIFO_DEPTH  4   request FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1                       clock, rising edge
//  nrst        in   1                       asynchronous active-low reset
//  req_valid   in   1                       request offered
//  req_ready   out  1                       FIFO can accept; = !full (no bypass)
//  req_vector  in   1                       1 = vector store (word per lane), 0 = scalar
//  req_size    in   2                       scalar size: 0 sb, 1 sh, 2 sw (3 = no write)
//  req_boff    in   2                       scalar byte offset within word
//  req_mask    in   NUM_LANES               vector lane enables (ignored for scalar)
//  req_addr    in   NUM_LANES*ADDR_W        per-lane word addresses, lane i at [i*ADDR_W +: ADDR_W]
//  req_data    in   NUM_LANES*32            per-lane store data
//  bank_we     out  NUM_BANKS*4             per-bank byte enables; bit b enables data[8b+7:8b]
//  bank_addr   out  NUM_BANKS*(ADDR_W-log2B) per-bank row address
//  bank_wdata  out  NUM_BANKS*32            per-bank write data
//  busy        out  1                       FIFO non-empty or dispatcher not IDLE
//  done        out  1                       one-cycle pulse with the final write cycle of a request
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, bank_we=0, bank_addr=0, bank_wdata=0, done=0, busy=0,
//    req_ready=1. Reset mid-operation drops all queued and in-flight requests; no partial writes
//    follow reset release.
//  - Push: on a clk edge with req_valid && req_ready. Simultaneous push and pop when not full are
//    both performed. Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
//  - Dispatcher FSM:
//    - IDLE: if FIFO non-empty, pop head into the working register and go to ISSUE.
//      pending = req_mask (vector) or 1'b1 on lane 0 (scalar).
//    - ISSUE: for each bank, grant the lowest-index pending lane whose address maps to it.
//      Register bank_we/addr/wdata for granted banks (others get we=0) and clear granted lanes.
//      When no lanes remain after this cycle, assert done. Then pop the next head directly (stay in
//      ISSUE) if the FIFO is non-empty, else return to IDLE.
//  - Outputs are registered. A conflict-free request accepted at edge T writes on the cycle after
//    edge T+2. k lanes on one bank take k ISSUE cycles.
//  - Vector: bank_we = 4'b1111 per granted lane; wdata = lane data unshifted. Same word address on
//    two lanes: the lower lane is written first, so the higher lane's data persists.
//  - Scalar: sb we = 4'b0001<<boff, data = {24'd0,d[7:0]}<<8*boff.
//    sh with boff 0/2: we = 4'b0011<<boff, data = {16'd0,d[15:0]}<<8*boff. sw with boff 0: we=1111.
//    Misaligned sh/sw or size 3: we = 0, request still completes with done.
//  - Empty vector mask: one ISSUE cycle, all we = 0, done pulses.
//  - bank_we is 0 in every cycle not carrying a grant. done never asserts without a completed request.
// TESTING
//  1. Reset: nrst low mid-ISSUE with 3 queued -> after release bank_we=0, busy=0, req_ready=1, no done.
//  2. Vector, mask 4'b1111, addrs 0,1,2,3 -> one cycle, all four banks we=1111, done pulses once.
//  3. Vector, addrs 4,8,12,5 (banks 0,0,0,1) -> 3 ISSUE cycles. Bank0 rows 1,2,3 in lane order;
//     bank1 row 1 in cycle 1; done in cycle 3.
//  4. Scalar sb boff=3 data 0xAB at addr 6 -> bank2 we=1000, wdata=0xAB000000, row 1.
//     sh boff=1 -> we=0, done.
//  5. Push 5 requests back-to-back with FIFO_DEPTH=4 while stalled -> req_ready drops after 4th.
//     All 5 complete in order, 5 done pulses.
//  6. Lanes 0 and 2 both at addr 7 with data A, B -> bank3 row 1 written A then B.
//     Final memory value is B.

Source files
------------

// File: rtl/store_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : store_bank_scheduler
//  Description : Buffers store requests in a small FIFO and issues every
//                lane's word to its memory bank. When several lanes target
//                the same bank, they are written over consecutive cycles in
//                lane order. Scalar sb/sh/sw stores (lane 0) get byte
//                enables and byte-shifted write data.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_bank_scheduler #(
    parameter int NUM_BANKS  = 4,
    parameter int NUM_LANES  = 4,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                             clk,
    input  logic                                             nrst,
    input  logic                                             req_valid,
    output logic                                             req_ready,
    input  logic                                             req_vector,
    input  logic [1:0]                                       req_size,
    input  logic [1:0]                                       req_boff,
    input  logic [NUM_LANES-1:0]                             req_mask,
    input  logic [NUM_LANES*ADDR_W-1:0]                      req_addr,
    input  logic [NUM_LANES*32-1:0]                          req_data,
    output logic [NUM_BANKS*4-1:0]                           bank_we,
    output logic [NUM_BANKS*(ADDR_W-$clog2(NUM_BANKS))-1:0]  bank_addr,
    output logic [NUM_BANKS*32-1:0]                          bank_wdata,
    output logic                                             busy,
    output logic                                             done
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W+1)'(1);
    localparam logic [NUM_LANES-1:0] LANE0 = NUM_LANES'(1);

    typedef struct packed {
        logic                        vector;
        logic [1:0]                  size;
        logic [1:0]                  boff;
        logic [NUM_LANES-1:0]        mask;
        logic [NUM_LANES*ADDR_W-1:0] addr;
        logic [NUM_LANES*32-1:0]     data;
    } req_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Queue storage and pointers; the extra pointer MSB separates full from empty
    req_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;

    // Dispatcher state and the request currently being issued
    state_t               state_q, state_d;
    req_t                 work_q, work_d;
    logic [NUM_LANES-1:0] pending_q, pending_d;

    // Registered bank-side outputs
    logic [NUM_BANKS*4-1:0]     we_q, we_d;
    logic [NUM_BANKS*ROW_W-1:0] addr_q, addr_d;
    logic [NUM_BANKS*32-1:0]    wdata_q, wdata_d;
    logic                       done_q, done_d;

    logic                 full_w;
    logic                 empty_w;
    logic                 push_w;
    logic                 pop_w;
    req_t                 push_entry_w;
    logic [NUM_LANES-1:0] grant_w;
    logic [NUM_LANES-1:0] remaining_w;
    logic [BANK_W-1:0]    lane_bank_w [NUM_LANES];
    logic [ROW_W-1:0]     lane_row_w  [NUM_LANES];
    logic [3:0]           scalar_be_w;
    logic [31:0]          scalar_data_w;

    assign full_w  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign push_w  = req_valid && !full_w;

    assign push_entry_w = '{vector: req_vector, size: req_size, boff: req_boff,
                            mask: req_mask, addr: req_addr, data: req_data};

    // Split each lane's word address into bank select and row
    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane_split
        assign lane_bank_w[gl] = work_q.addr[gl*ADDR_W +: BANK_W];
        assign lane_row_w[gl]  = work_q.addr[gl*ADDR_W+BANK_W +: ROW_W];
    end

    // Scalar byte enables and aligned data; unsupported size/offset writes nothing
    always_comb begin
        scalar_be_w   = 4'b0000;
        scalar_data_w = work_q.data[31:0];
        case (work_q.size)
            2'd0: begin
                scalar_be_w   = 4'b0001 << work_q.boff;
                scalar_data_w = {24'd0, work_q.data[7:0]} << {work_q.boff, 3'b000};
            end
            2'd1: begin
                if (!work_q.boff[0]) begin
                    scalar_be_w = 4'b0011 << work_q.boff;
                end
                scalar_data_w = {16'd0, work_q.data[15:0]} << {work_q.boff, 3'b000};
            end
            2'd2: begin
                if (work_q.boff == 2'd0) begin
                    scalar_be_w = 4'b1111;
                end
            end
            default: scalar_be_w = 4'b0000;
        endcase
    end

    // Each bank grants the lowest-index pending lane that maps onto it
    always_comb begin
        grant_w = '0;
        if (state_q == S_ISSUE) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                grant_w[l] = pending_q[l];
                for (int j = 0; j < l; j++) begin
                    if (pending_q[j] && (lane_bank_w[j] == lane_bank_w[l])) begin
                        grant_w[l] = 1'b0;
                    end
                end
            end
        end
    end

    // Next-state: bank outputs for this cycle's grants, dispatcher and FIFO pointers
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        pending_d   = pending_q;
        we_d        = '0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        pop_w       = 1'b0;
        wr_ptr_d    = push_w ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_w = pending_q & ~grant_w;

        for (int l = 0; l < NUM_LANES; l++) begin
            if (grant_w[l]) begin
                we_d[lane_bank_w[l]*4 +: 4]          = work_q.vector ? 4'b1111 : scalar_be_w;
                addr_d[lane_bank_w[l]*ROW_W +: ROW_W] = lane_row_w[l];
                wdata_d[lane_bank_w[l]*32 +: 32]     = work_q.vector ? work_q.data[l*32 +: 32]
                                                                     : scalar_data_w;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    pop_w   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pending_d = remaining_w;
                if (remaining_w == '0) begin
                    done_d = 1'b1;
                    if (!empty_w) begin
                        pop_w = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A popped request starts with all its enabled lanes pending
        if (pop_w) begin
            work_d    = fifo_mem[rd_ptr_q[PTR_W-1:0]];
            pending_d = work_d.vector ? work_d.mask : LANE0;
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end
    end

    // FIFO payload; validity is carried entirely by the reset pointers
    always_ff @(posedge clk) begin
        if (push_w) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_entry_w;
        end
    end

    // State registers; reset discards queued and in-flight requests
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= S_IDLE;
            work_q    <= '0;
            pending_q <= '0;
            we_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            work_q    <= work_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
        end
    end

    assign req_ready  = !full_w;
    assign busy       = !empty_w || (state_q != S_IDLE);
    assign bank_we    = we_q;
    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;
    assign done       = done_q;

endmodule
`default_nettype wire
